// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue-side sequencer for the datapath ALU.
// Accepts one decoded instruction, drives the ALU operand/control/shift
// inputs from registers, captures the ALU result one cycle later and holds
// it on a valid/ready output until the consumer takes it.
// Optional feature: define ALU_OVERFLOW_EN to enable signed-overflow
// detection on out_ovf (add, sub, addi). Without it out_ovf is tied low.
module alu_issue_ctrl #(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] ILLEGAL_RESULT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [15:0]      imm,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    output logic [4:0]       alu_shmnt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_branch_taken,
    output logic             out_illegal,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SLL = 4'b0101;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1011;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [4:0]       alu_shmnt_q, alu_shmnt_d;
    logic             is_beq_q, is_beq_d;
    logic             is_bne_q, is_bne_d;
    logic             is_ill_q, is_ill_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_zero_q, out_zero_d;
    logic             out_branch_q, out_branch_d;
    logic             out_illegal_q, out_illegal_d;

    // Decoded fields of the instruction currently on the input bus
    logic [WIDTH-1:0] dec_a, dec_b;
    logic [3:0]       dec_ctrl;
    logic [4:0]       dec_sh;
    logic             dec_beq, dec_bne, dec_ill;
    logic [WIDTH-1:0] imm_sext, imm_zext;

`ifdef ALU_OVERFLOW_EN
    logic ovf_add_q, ovf_add_d;
    logic ovf_sub_q, ovf_sub_d;
    logic out_ovf_q, out_ovf_d;
    logic dec_ovf_add, dec_ovf_sub;
`endif

    assign imm_sext = {{(WIDTH-16){imm[15]}}, imm};
    assign imm_zext = {{(WIDTH-16){1'b0}}, imm};

    // Instruction decode: opcode/funct to ALU control and operand selection
    always_comb begin
        dec_a    = rs_val;
        dec_b    = rt_val;
        dec_ctrl = CTRL_AND;
        dec_sh   = 5'd0;
        dec_beq  = 1'b0;
        dec_bne  = 1'b0;
        dec_ill  = 1'b0;
`ifdef ALU_OVERFLOW_EN
        dec_ovf_add = 1'b0;
        dec_ovf_sub = 1'b0;
`endif
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100000: begin
                        dec_ctrl = CTRL_ADD;
`ifdef ALU_OVERFLOW_EN
                        dec_ovf_add = 1'b1;
`endif
                    end
                    6'b100010: begin
                        dec_ctrl = CTRL_SUB;
`ifdef ALU_OVERFLOW_EN
                        dec_ovf_sub = 1'b1;
`endif
                    end
                    6'b100100: dec_ctrl = CTRL_AND;
                    6'b100101: dec_ctrl = CTRL_OR;
                    6'b101010: dec_ctrl = CTRL_SLT;
                    6'b100111: dec_ctrl = CTRL_NOR;
                    6'b000000: begin
                        dec_ctrl = CTRL_SLL;
                        dec_sh   = shamt;
                    end
                    default:   dec_ill  = 1'b1;
                endcase
            end
            6'b001000: begin
                dec_ctrl = CTRL_ADD;
                dec_b    = imm_sext;
`ifdef ALU_OVERFLOW_EN
                dec_ovf_add = 1'b1;
`endif
            end
            6'b100011, 6'b101011: begin
                dec_ctrl = CTRL_ADD;
                dec_b    = imm_sext;
            end
            6'b001100: begin
                dec_ctrl = CTRL_AND;
                dec_b    = imm_zext;
            end
            6'b001101: begin
                dec_ctrl = CTRL_OR;
                dec_b    = imm_zext;
            end
            6'b000100: begin
                dec_ctrl = CTRL_SUB;
                dec_beq  = 1'b1;
            end
            6'b000101: begin
                dec_ctrl = CTRL_SUB;
                dec_bne  = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        // Undecodable instructions present a quiet, all-zero ALU setup
        if (dec_ill) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_ctrl = CTRL_AND;
            dec_sh   = 5'd0;
        end
    end

    // Next-state and datapath register updates for IDLE -> EXEC -> DONE
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_ctrl_d    = alu_ctrl_q;
        alu_shmnt_d   = alu_shmnt_q;
        is_beq_d      = is_beq_q;
        is_bne_d      = is_bne_q;
        is_ill_d      = is_ill_q;
        out_result_d  = out_result_q;
        out_zero_d    = out_zero_q;
        out_branch_d  = out_branch_q;
        out_illegal_d = out_illegal_q;
`ifdef ALU_OVERFLOW_EN
        ovf_add_d = ovf_add_q;
        ovf_sub_d = ovf_sub_q;
        out_ovf_d = out_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = EXEC;
                    alu_a_d     = dec_a;
                    alu_b_d     = dec_b;
                    alu_ctrl_d  = dec_ctrl;
                    alu_shmnt_d = dec_sh;
                    is_beq_d    = dec_beq;
                    is_bne_d    = dec_bne;
                    is_ill_d    = dec_ill;
`ifdef ALU_OVERFLOW_EN
                    ovf_add_d = dec_ovf_add;
                    ovf_sub_d = dec_ovf_sub;
`endif
                end
            end
            EXEC: begin
                state_d       = DONE;
                out_result_d  = is_ill_q ? ILLEGAL_RESULT : alu_result;
                out_zero_d    = alu_zero;
                out_branch_d  = (is_beq_q & alu_zero) | (is_bne_q & ~alu_zero);
                out_illegal_d = is_ill_q;
`ifdef ALU_OVERFLOW_EN
                // A result sign that differs from A flags overflow for both
                // add (equal operand signs) and sub (differing operand signs)
                out_ovf_d = (alu_result[WIDTH-1] != alu_a_q[WIDTH-1]) &&
                            ((ovf_add_q && (alu_a_q[WIDTH-1] == alu_b_q[WIDTH-1])) ||
                             (ovf_sub_q && (alu_a_q[WIDTH-1] != alu_b_q[WIDTH-1])));
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset discards any instruction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_ctrl_q    <= 4'b0000;
            alu_shmnt_q   <= 5'd0;
            is_beq_q      <= 1'b0;
            is_bne_q      <= 1'b0;
            is_ill_q      <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_branch_q  <= 1'b0;
            out_illegal_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_add_q <= 1'b0;
            ovf_sub_q <= 1'b0;
            out_ovf_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_ctrl_q    <= alu_ctrl_d;
            alu_shmnt_q   <= alu_shmnt_d;
            is_beq_q      <= is_beq_d;
            is_bne_q      <= is_bne_d;
            is_ill_q      <= is_ill_d;
            out_result_q  <= out_result_d;
            out_zero_q    <= out_zero_d;
            out_branch_q  <= out_branch_d;
            out_illegal_q <= out_illegal_d;
`ifdef ALU_OVERFLOW_EN
            ovf_add_q <= ovf_add_d;
            ovf_sub_q <= ovf_sub_d;
            out_ovf_q <= out_ovf_d;
`endif
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign out_valid        = (state_q == DONE);
    assign alu_a            = alu_a_q;
    assign alu_b            = alu_b_q;
    assign alu_ctrl         = alu_ctrl_q;
    assign alu_shmnt        = alu_shmnt_q;
    assign out_result       = out_result_q;
    assign out_zero         = out_zero_q;
    assign out_branch_taken = out_branch_q;
    assign out_illegal      = out_illegal_q;
`ifdef ALU_OVERFLOW_EN
    assign out_ovf = out_ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule
